wide_add_seq: RTL and testbench

- Multi-cycle sequencer that adds two WORDS*W-bit operands by time-sharing one W-bit carrySelectAdder instance (N=W).
- Processes one W-bit slice per cycle, least-significant slice first, and chains the carry through a register.
- Sits between a valid/ready producer and consumer wherever a wide add is needed and a full-width adder is too costly.

---
 rtl/wide_add_seq.sv | 141 ++++++++++++++
 tb/tb_wide_add_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Purpose: wide adder that time-shares one W-bit carry-select adder across WORDS slices, LS slice first.
// Latency: acceptance at edge E0 -> out_valid high after edge E0+WORDS; one op per WORDS+2 cycles minimum.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    operand handshake (x, y, carryin[, sub])
//   out_valid/out_ready  result handshake (sum, carryout, overflow)
//   busy                 high while an operation is in RUN or DONE
// Optional build macro: SUBTRACT_EN adds the 'sub' input; sub=1 computes x-y
// (carryout=1 means no borrow, overflow is the signed-subtract overflow).
module wide_add_seq #(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] x,
  input  logic [W*WORDS-1:0] y,
  input  logic               carryin,
`ifdef SUBTRACT_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] sum,
  output logic               carryout,
  output logic               overflow,
  output logic               busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NB = W / 4;  // 4-bit carry-select blocks

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [W*WORDS-1:0]   x_reg, y_reg;
  logic                 carry_reg;
  logic [IW-1:0]        idx;
  logic                 last;

  // Shared slice adder signals
  logic [W-1:0]         add_a, add_b, add_sum;
  logic                 add_cout, add_ovf;
  logic [NB:0]          blk_c;

  assign add_a = x_reg[idx*W +: W];
  assign add_b = y_reg[idx*W +: W];
  assign last  = (idx == IW'(WORDS - 1));

  // W-bit carry-select adder: every 4-bit block precomputes its result for
  // both incoming carries, and the real carry only walks through the muxes.
  assign blk_c[0] = carry_reg;
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [4:0] r0, r1;
    assign r0 = {1'b0, add_a[4*k +: 4]} + {1'b0, add_b[4*k +: 4]};
    assign r1 = {1'b0, add_a[4*k +: 4]} + {1'b0, add_b[4*k +: 4]} + 5'd1;
    assign add_sum[4*k +: 4] = blk_c[k] ? r1[3:0] : r0[3:0];
    assign blk_c[k+1]        = blk_c[k] ? r1[4]   : r0[4];
  end
  assign add_cout = blk_c[NB];
  // Signed overflow: operands agree in sign but the result does not. Only
  // meaningful on the top slice, where it is the full-width overflow.
  assign add_ovf  = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x;
            idx   <= '0;
`ifdef SUBTRACT_EN
            // x - y = x + ~y + 1
            y_reg     <= sub ? ~y : y;
            carry_reg <= sub ? 1'b1 : carryin;
`else
            y_reg     <= y;
            carry_reg <= carryin;
`endif
          end
        end
        RUN: begin
          sum[idx*W +: W] <= add_sum;
          carry_reg       <= add_cout;
          if (last) begin
            idx      <= '0;
            carryout <= add_cout;
            overflow <= add_ovf;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;  // DONE holds the result
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Purpose: scoreboard bench for wide_add_seq (W=32, WORDS=4) with directed vectors.
// Latency: checks out_valid appears exactly WORDS edges after acceptance.
// Backpressure: exercises held results under out_ready=0 and reset mid-operation.
module tb_wide_add_seq;
  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int OW    = W * WORDS;

  localparam logic [OW-1:0] ONES = {OW{1'b1}};
  localparam logic [OW-1:0] MAXP = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINN = {1'b1, {(OW-1){1'b0}}};

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] x, y;
  logic          carryin;
`ifdef SUBTRACT_EN
  logic          sub;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] sum;
  logic          carryout;
  logic          overflow;
  logic          busy;

  typedef struct packed {
    logic [OW-1:0] s;
    logic          co;
    logic          ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  wide_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .carryin   (carryin),
`ifdef SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with no expected entry", sum);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum", sum, mon_e.s);
        chk("carryout", carryout, mon_e.co);
        chk("overflow", overflow, mon_e.ov);
      end
    end
  end

  // Present one operation, push its expectation, return #1 after acceptance.
  task automatic issue(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                       input logic sb, input logic [OW-1:0] es, input logic eco, input logic eov);
    chk("in_ready_idle", in_ready, 1);
    x        = a;
    y        = b;
    carryin  = cin;
`ifdef SUBTRACT_EN
    sub      = sb;
`else
    if (sb) $display("note: subtract requested in add-only build");
`endif
    in_valid = 1'b1;
    sb_q.push_back('{es, eco, eov});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the inputs: the DUT must use its latched copy.
    x = ~a;
    y = ~b;
    carryin = ~cin;
  endtask

  // Count edges until out_valid, checking busy along the way.
  task automatic wait_done(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      chk({name, "_busy"}, busy, 1);
      chk({name, "_in_ready_run"}, in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, n, WORDS);
    chk({name, "_busy_done"}, busy, 1);
  endtask

  // With out_ready high, result leaves and the DUT is back in IDLE next edge.
  task automatic back_to_idle(input string name);
    @(posedge clk);
    #1;
    chk({name, "_out_valid_low"}, out_valid, 0);
    chk({name, "_in_ready_high"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    carryin   = 1'b0;
`ifdef SUBTRACT_EN
    sub       = 1'b0;
`endif
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carryout", carryout, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1 + 1
    issue(1, 1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    wait_done("one_plus_one");
    back_to_idle("one_plus_one");

    // all ones + 0 + carryin: carry ripples through every slice boundary
    issue(ONES, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    wait_done("carry_chain");
    back_to_idle("carry_chain");

    // max positive + 1: signed overflow
    issue(MAXP, 1, 1'b0, 1'b0, MINN, 1'b0, 1'b1);
    wait_done("pos_ovf");
    back_to_idle("pos_ovf");

    // min negative + min negative: carry and overflow together
    issue(MINN, MINN, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    wait_done("neg_ovf");
    back_to_idle("neg_ovf");

    // Backpressure: result held while out_ready=0, inputs ignored
    out_ready = 1'b0;
    issue(3, 5, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_done("hold");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = x + 128'd17;
      @(posedge clk);
      #1;
      chk("hold_sum", sum, 8);
      chk("hold_carryout", carryout, 0);
      chk("hold_overflow", overflow, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    back_to_idle("hold");

    // Reset while idx==2 in RUN: partial result discarded
    issue(ONES, ONES, 1'b0, 1'b0, ONES - 1, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3, 4, 1'b0, 1'b0, 7, 1'b0, 1'b0);
    wait_done("after_rst");
    back_to_idle("after_rst");

`ifdef SUBTRACT_EN
    // 5 - 7 = -2, borrow
    issue(5, 7, 1'b1, 1'b1, ONES - 1, 1'b0, 1'b0);
    wait_done("sub_neg");
    back_to_idle("sub_neg");
    // 7 - 5 = 2, no borrow
    issue(7, 5, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    wait_done("sub_pos");
    back_to_idle("sub_pos");
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
